// File: rtl/gpu_cmd_dispatch.sv
// rtl/gpu_cmd_dispatch.sv - in-order multi-channel GPU command issue unit with barrier
module gpu_cmd_dispatch #(
  parameter int CMD_W = 3,
  parameter int ARG_W = 16,
  parameter int DEPTH = 4,
  parameter int NUM_CH = 2,
  parameter logic [CMD_W-1:0] BARRIER_CODE = {CMD_W{1'b1}},
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH) + 1
) (
  input  logic                    Clk,
  input  logic                    Reset_n,
  input  logic                    cmd_valid,
  input  logic [CMD_W-1:0]        cmd_code,
  input  logic [ARG_W-1:0]        cmd_arg,
  input  logic [CH_W-1:0]         cmd_ch,
  output logic                    cmd_ready,
  output logic [NUM_CH*CMD_W-1:0] ch_command,
  output logic [NUM_CH*ARG_W-1:0] ch_arg,
  output logic [NUM_CH-1:0]       ch_command_ready,
  input  logic [NUM_CH-1:0]       ch_command_received,
  input  logic [NUM_CH-1:0]       ch_done,
  output logic                    barrier_done,
  output logic [CNT_W-1:0]        fifo_count,
  output logic                    idle,
  output logic                    proto_err
);

  typedef enum logic [1:0] {CH_IDLE, CH_ISSUE, CH_RUN} ch_state_t;

  localparam logic [CH_W:0] NUM_CH_L = NUM_CH[CH_W:0];

  ch_state_t        ch_state     [NUM_CH];
  ch_state_t        ch_state_nxt [NUM_CH];
  logic [CMD_W-1:0] ch_code_q    [NUM_CH];
  logic [ARG_W-1:0] ch_arg_q     [NUM_CH];

  logic [CMD_W-1:0] fifo_code [DEPTH];
  logic [ARG_W-1:0] fifo_arg  [DEPTH];
  logic [CH_W-1:0]  fifo_ch   [DEPTH];
  logic [PTR_W-1:0] rd_ptr, wr_ptr;

  logic             head_bar, all_idle, head_ch_idle;
  logic             bad_ch, push, pop;
  logic [CH_W-1:0]  head_ch;
  logic [NUM_CH-1:0] issue_vec, idle_err;

  assign cmd_ready = (fifo_count != CNT_W'(DEPTH));
  assign head_bar  = (fifo_code[rd_ptr] == BARRIER_CODE);
  assign head_ch   = fifo_ch[rd_ptr];
  assign bad_ch    = (cmd_code != BARRIER_CODE) && ({1'b0, cmd_ch} >= NUM_CH_L);
  assign push      = cmd_valid && cmd_ready && !bad_ch;
  assign pop       = (fifo_count != '0) && (head_bar ? all_idle : head_ch_idle);
  assign idle      = (fifo_count == '0) && all_idle;

  // Summarise channel occupancy for the head-of-queue pop decision
  always_comb begin
    all_idle     = 1'b1;
    head_ch_idle = 1'b0;
    issue_vec    = '0;
    idle_err     = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      if (ch_state[i] != CH_IDLE) all_idle = 1'b0;
      if (head_ch == CH_W'(i) && ch_state[i] == CH_IDLE) head_ch_idle = 1'b1;
      issue_vec[i] = pop && !head_bar && (head_ch == CH_W'(i));
      idle_err[i]  = (ch_state[i] == CH_IDLE) && (ch_done[i] || ch_command_received[i]);
    end
  end

  // Queue storage; contents are only meaningful between the pointers
  always_ff @(posedge Clk) begin
    if (push) begin
      fifo_code[wr_ptr] <= cmd_code;
      fifo_arg[wr_ptr]  <= cmd_arg;
      fifo_ch[wr_ptr]   <= cmd_ch;
    end
  end

  // Queue pointers and occupancy; a pop never frees room for a same-cycle push
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + 1'b1;
        2'b01:   fifo_count <= fifo_count - 1'b1;
        default: fifo_count <= fifo_count;
      endcase
    end
  end

  // Channel state register
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CH; i++) ch_state[i] <= CH_IDLE;
    end else begin
      for (int i = 0; i < NUM_CH; i++) ch_state[i] <= ch_state_nxt[i];
    end
  end

  // Channel next-state: issue on pop, run after receipt, idle on done
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      ch_state_nxt[i] = ch_state[i];
      case (ch_state[i])
        CH_IDLE:  if (issue_vec[i]) ch_state_nxt[i] = CH_ISSUE;
        CH_ISSUE: if (ch_command_received[i]) ch_state_nxt[i] = ch_done[i] ? CH_IDLE : CH_RUN;
        CH_RUN:   if (ch_done[i]) ch_state_nxt[i] = CH_IDLE;
        default:  ch_state_nxt[i] = CH_IDLE;
      endcase
    end
  end

  // Channel outputs decoded from registered state; idle channels show the no-op code
  always_comb begin
    ch_command       = '0;
    ch_arg           = '0;
    ch_command_ready = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_command_ready[i] = (ch_state[i] == CH_ISSUE);
      ch_command[i*CMD_W +: CMD_W] = (ch_state[i] == CH_IDLE) ? BARRIER_CODE : ch_code_q[i];
      ch_arg[i*ARG_W +: ARG_W]     = (ch_state[i] == CH_IDLE) ? '0 : ch_arg_q[i];
    end
  end

  // Latch the popped command into its channel so it stays stable while issued
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        ch_code_q[i] <= BARRIER_CODE;
        ch_arg_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (issue_vec[i]) begin
          ch_code_q[i] <= fifo_code[rd_ptr];
          ch_arg_q[i]  <= fifo_arg[rd_ptr];
        end
      end
    end
  end

  // Barrier retirement pulse and sticky protocol error
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      barrier_done <= 1'b0;
      proto_err    <= 1'b0;
    end else begin
      barrier_done <= pop && head_bar;
      if ((|idle_err) || (cmd_valid && cmd_ready && bad_ch)) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_gpu_cmd_dispatch.sv
// tb/tb_gpu_cmd_dispatch.sv - directed and randomized checks of gpu_cmd_dispatch against a queue model
module tb_gpu_cmd_dispatch;

  localparam int CMD_W = 3;
  localparam int ARG_W = 16;
  localparam int DEPTH = 4;
  localparam int NUM_CH = 2;
  localparam logic [2:0] BAR = 3'b111;

  logic        Clk = 1'b0;
  logic        Reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic [2:0]  cmd_code = '0;
  logic [15:0] cmd_arg = '0;
  logic [0:0]  cmd_ch = '0;
  logic        cmd_ready;
  logic [5:0]  ch_command;
  logic [31:0] ch_arg;
  logic [1:0]  ch_command_ready;
  logic [1:0]  rcv = '0;
  logic [1:0]  dn = '0;
  logic        barrier_done;
  logic [2:0]  fifo_count;
  logic        idle;
  logic        proto_err;

  int checks = 0;
  int failures = 0;

  gpu_cmd_dispatch #(.CMD_W(CMD_W), .ARG_W(ARG_W), .DEPTH(DEPTH), .NUM_CH(NUM_CH)) dut (
    .Clk(Clk), .Reset_n(Reset_n), .cmd_valid(cmd_valid), .cmd_code(cmd_code),
    .cmd_arg(cmd_arg), .cmd_ch(cmd_ch), .cmd_ready(cmd_ready), .ch_command(ch_command),
    .ch_arg(ch_arg), .ch_command_ready(ch_command_ready), .ch_command_received(rcv),
    .ch_done(dn), .barrier_done(barrier_done), .fifo_count(fifo_count), .idle(idle),
    .proto_err(proto_err)
  );

  always #5 Clk = ~Clk;

  // Reference model: pending commands in a queue, each channel either free or
  // holding one command that is still waiting to be accepted or executing.
  typedef struct {
    logic [2:0]  code;
    logic [15:0] arg;
    int          ch;
  } ent_t;

  ent_t        mq[$];
  bit          m_busy [NUM_CH];
  bit          m_wait [NUM_CH];
  logic [2:0]  m_code [NUM_CH];
  logic [15:0] m_arg  [NUM_CH];
  bit          m_perr, m_bdone;

  task automatic model_edge();
    bit   full, any_busy, do_pop, hbar;
    ent_t h, e;
    if (!Reset_n) begin
      mq.delete();
      for (int i = 0; i < NUM_CH; i++) begin m_busy[i] = 0; m_wait[i] = 0; end
      m_perr = 0; m_bdone = 0;
      return;
    end
    full = (mq.size() == DEPTH);
    any_busy = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_busy[i]) any_busy = 1;
    do_pop = 0; hbar = 0;
    if (mq.size() > 0) begin
      h = mq[0];
      hbar = (h.code == BAR);
      do_pop = hbar ? !any_busy : !m_busy[h.ch];
    end
    for (int i = 0; i < NUM_CH; i++) begin
      if (!m_busy[i]) begin
        if (rcv[i] || dn[i]) m_perr = 1;
      end else if (m_wait[i]) begin
        if (rcv[i]) begin
          m_wait[i] = 0;
          if (dn[i]) m_busy[i] = 0;
        end
      end else if (dn[i]) begin
        m_busy[i] = 0;
      end
    end
    m_bdone = do_pop && hbar;
    if (do_pop) begin
      void'(mq.pop_front());
      if (!hbar) begin
        m_busy[h.ch] = 1; m_wait[h.ch] = 1;
        m_code[h.ch] = h.code; m_arg[h.ch] = h.arg;
      end
    end
    if (cmd_valid && !full) begin
      e.code = cmd_code; e.arg = cmd_arg; e.ch = int'(cmd_ch);
      mq.push_back(e);
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic compare_all();
    bit any_busy;
    any_busy = 0;
    for (int i = 0; i < NUM_CH; i++) if (m_busy[i]) any_busy = 1;
    chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
    chk("cmd_ready", 32'(cmd_ready), 32'(mq.size() < DEPTH));
    chk("idle", 32'(idle), 32'(mq.size() == 0 && !any_busy));
    chk("barrier_done", 32'(barrier_done), 32'(m_bdone));
    chk("proto_err", 32'(proto_err), 32'(m_perr));
    for (int i = 0; i < NUM_CH; i++) begin
      chk($sformatf("ch%0d_ready", i), 32'(ch_command_ready[i]), 32'(m_busy[i] && m_wait[i]));
      if (!m_busy[i]) begin
        chk($sformatf("ch%0d_idle_code", i), 32'(ch_command[i*3 +: 3]), 32'(BAR));
        chk($sformatf("ch%0d_idle_arg", i), 32'(ch_arg[i*16 +: 16]), 32'd0);
      end else if (m_wait[i]) begin
        chk($sformatf("ch%0d_code", i), 32'(ch_command[i*3 +: 3]), 32'(m_code[i]));
        chk($sformatf("ch%0d_arg", i), 32'(ch_arg[i*16 +: 16]), 32'(m_arg[i]));
      end
    end
  endtask

  task automatic step();
    @(posedge Clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic push(input logic [2:0] code, input logic [15:0] arg, input logic [0:0] ch);
    cmd_valid = 1'b1; cmd_code = code; cmd_arg = arg; cmd_ch = ch;
    step();
    cmd_valid = 1'b0;
  endtask

  initial begin
    logic [2:0] expc [5];
    int n;
    expc = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5};

    // Reset state
    Reset_n = 1'b0;
    step(); step();
    Reset_n = 1'b1;
    chk("rst_fifo_count", 32'(fifo_count), 32'd0);
    chk("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst_idle", 32'(idle), 32'd1);
    chk("rst_ch_command", 32'(ch_command), 32'h3f);
    chk("rst_ch_ready", 32'(ch_command_ready), 32'd0);

    // Single command: issue latency, receipt, completion
    push(3'd0, 16'h1234, 1'b0);
    chk("lat_ready_before", 32'(ch_command_ready), 32'd0);
    step();
    chk("lat_ready", 32'(ch_command_ready), 32'b01);
    chk("lat_code", 32'(ch_command[2:0]), 32'd0);
    chk("lat_arg", 32'(ch_arg[15:0]), 32'h1234);
    step();
    chk("hold_arg", 32'(ch_arg[15:0]), 32'h1234);
    rcv = 2'b01; step(); rcv = 2'b00;
    chk("rcv_ready_low", 32'(ch_command_ready), 32'd0);
    chk("run_not_idle", 32'(idle), 32'd0);
    step();
    dn = 2'b01; step(); dn = 2'b00;
    chk("done_idle", 32'(idle), 32'd1);

    // Fill the queue behind a stalled channel; overflow push is ignored
    push(3'd1, 16'h0011, 1'b0);
    push(3'd2, 16'h0022, 1'b0);
    push(3'd3, 16'h0033, 1'b0);
    push(3'd4, 16'h0044, 1'b0);
    chk("fill_count3", 32'(fifo_count), 32'd3);
    push(3'd5, 16'h0055, 1'b0);
    chk("fill_count4", 32'(fifo_count), 32'd4);
    chk("full_not_ready", 32'(cmd_ready), 32'd0);
    push(3'd6, 16'h0066, 1'b0);
    chk("full_ignored", 32'(fifo_count), 32'd4);
    chk("full_no_err", 32'(proto_err), 32'd0);
    for (int j = 0; j < 5; j++) begin
      n = 0;
      while (!ch_command_ready[0] && n < 20) begin step(); n++; end
      chk("order_wait_bound", 32'(n < 20), 32'd1);
      chk("order_code", 32'(ch_command[2:0]), 32'(expc[j]));
      rcv = 2'b01; dn = 2'b01; step(); rcv = 2'b00; dn = 2'b00;
    end
    step();
    chk("drain_idle", 32'(idle), 32'd1);

    // Barrier between two channels
    push(3'd1, 16'h0a01, 1'b0);
    push(3'd2, 16'h0b02, 1'b1);
    chk("bar_ch0_issued", 32'(ch_command_ready[0]), 32'd1);
    push(BAR, 16'h0000, 1'b0);
    chk("bar_ch1_issued", 32'(ch_command_ready[1]), 32'd1);
    push(3'd3, 16'h0c03, 1'b0);
    rcv = 2'b11; step(); rcv = 2'b00;
    dn = 2'b01; step(); dn = 2'b00;
    step(); step();
    chk("bar_waiting", 32'(barrier_done), 32'd0);
    chk("bar_held_code3", 32'(ch_command_ready[0]), 32'd0);
    dn = 2'b10; step(); dn = 2'b00;
    step();
    chk("bar_pulse", 32'(barrier_done), 32'd1);
    chk("bar_no_issue_yet", 32'(ch_command_ready), 32'd0);
    step();
    chk("bar_pulse_end", 32'(barrier_done), 32'd0);
    chk("bar_code3_ready", 32'(ch_command_ready[0]), 32'd1);
    chk("bar_code3", 32'(ch_command[2:0]), 32'd3);
    rcv = 2'b01; dn = 2'b01; step(); rcv = 2'b00; dn = 2'b00;

    // Spurious done on an idle channel is sticky
    dn = 2'b10; step(); dn = 2'b00;
    chk("perr_set", 32'(proto_err), 32'd1);
    push(3'd2, 16'h0202, 1'b1);
    step();
    rcv = 2'b10; dn = 2'b10; step(); rcv = 2'b00; dn = 2'b00;
    chk("perr_sticky", 32'(proto_err), 32'd1);

    // Reset while a channel runs and entries are queued
    push(3'd1, 16'haaaa, 1'b0);
    step();
    rcv = 2'b01; step(); rcv = 2'b00;
    push(3'd2, 16'hbbbb, 1'b0);
    push(3'd3, 16'hcccc, 1'b0);
    chk("mid_count", 32'(fifo_count), 32'd2);
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    chk("mid_rst_count", 32'(fifo_count), 32'd0);
    chk("mid_rst_idle", 32'(idle), 32'd1);
    chk("mid_rst_perr", 32'(proto_err), 32'd0);
    chk("mid_rst_ready", 32'(ch_command_ready), 32'd0);
    step();
    chk("mid_rst_no_bar", 32'(barrier_done), 32'd0);
    dn = 2'b01; step(); dn = 2'b00;
    chk("mid_rst_late_done", 32'(proto_err), 32'd1);

    // Randomized legal traffic against the model
    Reset_n = 1'b0; step(); Reset_n = 1'b1;
    for (int c = 0; c < 800; c++) begin
      cmd_valid = ($urandom % 3) == 0;
      cmd_code  = 3'($urandom % 8);
      cmd_arg   = 16'($urandom);
      cmd_ch    = 1'($urandom % 2);
      for (int i = 0; i < NUM_CH; i++) begin
        rcv[i] = 1'b0; dn[i] = 1'b0;
        if (m_busy[i] && m_wait[i]) begin
          rcv[i] = ($urandom % 2) == 0;
          dn[i]  = rcv[i] && (($urandom % 4) == 0);
        end else if (m_busy[i]) begin
          dn[i] = ($urandom % 3) == 0;
        end
      end
      Reset_n = (($urandom % 250) != 0);
      step();
    end
    Reset_n = 1'b1; cmd_valid = 1'b0; rcv = 2'b00; dn = 2'b00;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
